// File: rtl/lab5_fetch_unit.sv
// lab5_fetch_unit: instruction fetch sequencer on the read side of a 128x16 IRAM.
// Holds the PC, registers fetched words into INSTR, parks on HALT until a
// synchronized CONT rising edge, and redirects on taken branches.
// Optional feature macro: FETCH_SINGLE_STEP_EN (adds step_mode input; each
// issued instruction then parks the unit until the next CONT edge).
module lab5_fetch_unit #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [15:0] HALT_WORD   = 16'h0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic        step_mode,
`endif
    output logic [7:0]  iaddr,
    input  logic [15:0] idata,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    input  logic        cont,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic [2:0]  halt_cnt
);

    // Byte addresses into a 16-bit wide RAM are always even.
    localparam logic [7:0] RESET_PC_EVEN = RESET_PC & 8'hFE;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    logic        valid_reg, valid_next;
    logic        halted_reg, halted_next;
    logic [2:0]  halt_cnt_reg, halt_cnt_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   cont_prev_reg;
    logic                   cont_rise;
    logic                   step_active;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_active = step_mode;
`else
    assign step_active = 1'b0;
`endif

    // CONT synchronizer chain: stage 0 samples the raw pin, later stages follow.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First flop captures the asynchronous pushbutton level.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= cont;
                end
            end else begin : g_next
                // Subsequent flops resolve metastability.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Edge detector history flop; runs in every state so stale edges are never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cont_prev_reg <= 1'b0;
        else        cont_prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign cont_rise = sync_reg[SYNC_STAGES-1] & ~cont_prev_reg;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC_EVEN;
            instr_reg    <= 16'h0000;
            valid_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            halt_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            valid_reg    <= valid_next;
            halted_reg   <= halted_next;
            halt_cnt_reg <= halt_cnt_next;
        end
    end

    // Next-state logic: branch beats HALT pre-decode, which beats a normal issue.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        valid_next    = 1'b0;
        halted_next   = halted_reg;
        halt_cnt_next = halt_cnt_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (br_taken) begin
                    // The word fetched this cycle is squashed, giving one bubble.
                    pc_next = br_target & 8'hFE;
                end else if (idata == HALT_WORD) begin
                    pc_next       = pc_reg + 8'd2;
                    halted_next   = 1'b1;
                    halt_cnt_next = halt_cnt_reg + 3'd1;
                    state_next    = ST_HALT;
                end else begin
                    instr_next = idata;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + 8'd2;
                    if (step_active) begin
                        halted_next = 1'b1;
                        state_next  = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // Branch requests are ignored here; only a CONT edge resumes.
                if (cont_rise) begin
                    halted_next = 1'b0;
                    state_next  = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign iaddr       = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign halted      = halted_reg;
    assign halt_cnt    = halt_cnt_reg;

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// tb_lab5_fetch_unit: directed bench for the fetch unit with a behavioural IRAM.
module tb_lab5_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  iaddr;
    logic [15:0] idata;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        cont;
    logic [15:0] instr;
    logic        instr_valid;
    logic        halted;
    logic [2:0]  halt_cnt;
`ifdef FETCH_SINGLE_STEP_EN
    logic        step_mode;
`endif

    logic [15:0] iram [0:127];
    int total;
    int bad;

    lab5_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FETCH_SINGLE_STEP_EN
        .step_mode   (step_mode),
`endif
        .iaddr       (iaddr),
        .idata       (idata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .cont        (cont),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .halt_cnt    (halt_cnt)
    );

    // Combinational IRAM read, word-addressed by iaddr[7:1].
    assign idata = iram[iaddr[7:1]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a running cycle: address presented and the issued word.
    task automatic chk_issue(input string tag, input logic [7:0] a, input logic [15:0] w);
        chk({tag, " iaddr"}, {24'h0, iaddr}, {24'h0, a});
        chk({tag, " instr"}, {16'h0, instr}, {16'h0, w});
        chk({tag, " valid"}, {31'h0, instr_valid}, 32'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) iram[i] = 16'h1000 + 16'(i);
        iram[3]    = 16'h0001;   // HALT at byte 0x06
        iram[8'h22] = 16'h0001;  // HALT at byte 0x44, hit together with a branch
        rst_n     = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
        cont      = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step_mode = 1'b0;
`endif

        // Reset values, before any clock edge.
        #2;
        chk("rst iaddr", {24'h0, iaddr}, 32'h00);
        chk("rst instr", {16'h0, instr}, 32'h0);
        chk("rst valid", {31'h0, instr_valid}, 32'h0);
        chk("rst halted", {31'h0, halted}, 32'h0);
        chk("rst cnt", {29'h0, halt_cnt}, 32'h0);
        #10 rst_n = 1'b1;

        // Test 1: boot, three words, then HALT.
        step();
        chk("boot iaddr", {24'h0, iaddr}, 32'h00);
        chk("boot valid", {31'h0, instr_valid}, 32'h0);
        step(); chk_issue("t1 w0", 8'h02, 16'h1000);
        step(); chk_issue("t1 w1", 8'h04, 16'h1001);
        step(); chk_issue("t1 w2", 8'h06, 16'h1002);
        step();
        chk("t1 halt valid", {31'h0, instr_valid}, 32'h0);
        chk("t1 halted", {31'h0, halted}, 32'h1);
        chk("t1 pc", {24'h0, iaddr}, 32'h08);
        chk("t1 cnt", {29'h0, halt_cnt}, 32'h1);
        chk("t1 instr hold", {16'h0, instr}, 32'h1002);
        step();
        chk("t1 park halted", {31'h0, halted}, 32'h1);
        chk("t1 park pc", {24'h0, iaddr}, 32'h08);

        // Test 2: CONT held 5 cycles resumes once, after the 2-stage sync + edge.
        cont = 1'b1;
        step(); chk("t2 c1 halted", {31'h0, halted}, 32'h1);
        step(); chk("t2 c2 halted", {31'h0, halted}, 32'h1);
        step();
        chk("t2 c3 halted", {31'h0, halted}, 32'h0);
        chk("t2 c3 iaddr", {24'h0, iaddr}, 32'h08);
        chk("t2 c3 valid", {31'h0, instr_valid}, 32'h0);
        step(); chk_issue("t2 w08", 8'h0A, 16'h1004);
        step(); chk_issue("t2 w0A", 8'h0C, 16'h1005);
        cont = 1'b0;
        step(); chk_issue("t2 w0C", 8'h0E, 16'h1006);
        cont = 1'b1;  // second pulse while running
        step(); chk_issue("t2 w0E", 8'h10, 16'h1007);
        step(); chk_issue("t2 w10", 8'h12, 16'h1008);
        chk("t2 run halted", {31'h0, halted}, 32'h0);

        // Test 3: branch to 0x41 while 0x10 is in INSTR; 0x12 is squashed.
        cont      = 1'b0;
        br_taken  = 1'b1;
        br_target = 8'h41;
        step();
        br_taken = 1'b0;
        chk("t3 iaddr", {24'h0, iaddr}, 32'h40);
        chk("t3 bubble", {31'h0, instr_valid}, 32'h0);
        step(); chk_issue("t3 w40", 8'h42, 16'h1020);
        step(); chk_issue("t3 w42", 8'h44, 16'h1021);

        // Test 5: branch wins over the HALT word now on idata; then Test 4 wrap.
        br_taken  = 1'b1;
        br_target = 8'hFC;
        step();
        br_taken = 1'b0;
        chk("t5 iaddr", {24'h0, iaddr}, 32'hFC);
        chk("t5 halted", {31'h0, halted}, 32'h0);
        chk("t5 cnt", {29'h0, halt_cnt}, 32'h1);
        chk("t5 valid", {31'h0, instr_valid}, 32'h0);
        step(); chk_issue("t4 wFC", 8'hFE, 16'h107E);
        step(); chk_issue("t4 wFE", 8'h00, 16'h107F);
        step(); chk_issue("t4 w00", 8'h02, 16'h1000);
        step(); chk_issue("t4 w02", 8'h04, 16'h1001);
        step(); chk_issue("t4 w04", 8'h06, 16'h1002);
        step();
        chk("t4 halted", {31'h0, halted}, 32'h1);
        chk("t4 cnt", {29'h0, halt_cnt}, 32'h2);
        chk("t4 pc", {24'h0, iaddr}, 32'h08);

        // The RUN-time CONT edge was not remembered, and branches are ignored in HALT.
        br_taken  = 1'b1;
        br_target = 8'h20;
        step();
        br_taken = 1'b0;
        step();
        chk("hold halted", {31'h0, halted}, 32'h1);
        chk("hold pc", {24'h0, iaddr}, 32'h08);
        chk("hold valid", {31'h0, instr_valid}, 32'h0);

        // Resume again, then Test 6: asynchronous reset mid-run.
        cont = 1'b1;
        step(); step(); step();
        chk("t6 resume", {31'h0, halted}, 32'h0);
        step(); chk_issue("t6 w08", 8'h0A, 16'h1004);
        cont = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t6 iaddr", {24'h0, iaddr}, 32'h00);
        chk("t6 instr", {16'h0, instr}, 32'h0);
        chk("t6 valid", {31'h0, instr_valid}, 32'h0);
        chk("t6 halted", {31'h0, halted}, 32'h0);
        chk("t6 cnt", {29'h0, halt_cnt}, 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk("t6 boot iaddr", {24'h0, iaddr}, 32'h00);
        chk("t6 boot valid", {31'h0, instr_valid}, 32'h0);
        step(); chk_issue("t6 w00", 8'h02, 16'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
